wb_bus_switch_n: RTL and testbench

Parametrised two-master, N-slave Wishbone classic interconnect. It is the successor to the fixed single-master memory and peripheral bus switches. It arbitrates the BIU instruction and data ports round-robin, decodes the address against a per-slave base/mask map, and routes one transaction at a time. Unmapped addresses and hung slaves return a one-cycle bus error instead of stalling the core.

---
 rtl/wb_switch_pkg.sv | 25 ++
 rtl/wb_addr_decoder.sv | 42 ++++
 rtl/wb_bus_switch_n.sv | 149 ++++++++++++++
 tb/tb_wb_bus_switch_n.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_switch_pkg.sv
// Shared definitions for the Wishbone bus switch.
//   state_t : FSM states of the switch (IDLE, BUSY, ERR)
//   M0, M1  : master indices (M0 = instruction port, M1 = data port)
//   clog2   : ceiling log2, used for index and counter widths
package wb_switch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder for the Wishbone bus switch.
//   adr : address presented by the master being granted
//   hit : at least one slave window matches adr
//   idx : index of the lowest-numbered matching slave (0 when no hit)
// Slave k matches when (adr & MASK_k) == (BASE_k & MASK_k); base/mask
// vectors are packed with slave 0 in the least significant bits.
module wb_addr_decoder
  import wb_switch_pkg::*;
#(
  parameter int NUM_SLAVES = 7,
  parameter int ADDR_W = 32,
  parameter int IDX_W = 3,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0] adr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_SLAVES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = ((adr & SLAVE_MASK[gi*ADDR_W +: ADDR_W]) ==
                          (SLAVE_BASE[gi*ADDR_W +: ADDR_W] & SLAVE_MASK[gi*ADDR_W +: ADDR_W]));
    end
  endgenerate

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_bus_switch_n.sv
// Two-master, N-slave Wishbone classic interconnect.
//   clk_i, rst_i          : clock, synchronous active-low reset
//   m0_* / m1_*           : instruction / data master ports (stb, we, adr,
//                           dat, sel in; dat, ack, err out)
//   slave_cyc_o/stb_o     : one-hot per-slave cycle and strobe
//   slave_we/adr/dat/sel_o: shared request bus, muxed from the granted master
//   slave_dat_i/ack_i     : packed per-slave read data and acks
// Masters are arbitrated round-robin in IDLE, one transfer at a time.
// Unmapped addresses and slaves that never ack produce a one-cycle err.
module wb_bus_switch_n
  import wb_switch_pkg::*;
#(
  parameter int NUM_SLAVES = 7,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {
    32'h1000_0600, 32'h1000_0500, 32'h1000_0400, 32'h1000_0300,
    32'h1000_0200, 32'h1000_0100, 32'h1000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FF00}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m0_stb_i,
  input  logic                         m0_we_i,
  input  logic [ADDR_W-1:0]            m0_adr_i,
  input  logic [DATA_W-1:0]            m0_dat_i,
  input  logic [DATA_W/8-1:0]          m0_sel_i,
  output logic [DATA_W-1:0]            m0_dat_o,
  output logic                         m0_ack_o,
  output logic                         m0_err_o,
  input  logic                         m1_stb_i,
  input  logic                         m1_we_i,
  input  logic [ADDR_W-1:0]            m1_adr_i,
  input  logic [DATA_W-1:0]            m1_dat_i,
  input  logic [DATA_W/8-1:0]          m1_sel_i,
  output logic [DATA_W-1:0]            m1_dat_o,
  output logic                         m1_ack_o,
  output logic                         m1_err_o,
  output logic [NUM_SLAVES-1:0]        slave_cyc_o,
  output logic [NUM_SLAVES-1:0]        slave_stb_o,
  output logic                         slave_we_o,
  output logic [ADDR_W-1:0]            slave_adr_o,
  output logic [DATA_W-1:0]            slave_dat_o,
  output logic [DATA_W/8-1:0]          slave_sel_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_dat_i,
  input  logic [NUM_SLAVES-1:0]        slave_ack_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_reg;
  logic              grant_reg;
  logic              last_grant_reg;
  logic [IDX_W-1:0]  slave_idx_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              grant_next;
  logic [ADDR_W-1:0] req_adr;
  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              busy;
  logic              granted_stb;
  logic              sel_ack;
  logic [DATA_W-1:0] sel_rdata;
  logic [DATA_W-1:0] rdata_arr [NUM_SLAVES];

  // Round-robin: on a tie the master that did not win last time goes next.
  always_comb begin
    grant_next = M0;
    if (m0_stb_i && m1_stb_i) grant_next = ~last_grant_reg;
    else if (m1_stb_i)        grant_next = M1;
  end

  assign req_adr = (grant_next == M1) ? m1_adr_i : m0_adr_i;

  wb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .adr (req_adr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign rdata_arr[gi]   = slave_dat_i[gi*DATA_W +: DATA_W];
      assign slave_stb_o[gi] = busy && (slave_idx_reg == IDX_W'(gi));
      assign slave_cyc_o[gi] = slave_stb_o[gi];
    end
  endgenerate

  assign busy        = (state_reg == BUSY);
  assign granted_stb = (grant_reg == M1) ? m1_stb_i : m0_stb_i;
  assign sel_ack     = slave_ack_i[slave_idx_reg];
  assign sel_rdata   = rdata_arr[slave_idx_reg];

  // Shared request bus follows the granted master only while a slave is strobed.
  assign slave_we_o  = busy && ((grant_reg == M1) ? m1_we_i : m0_we_i);
  assign slave_adr_o = busy ? ((grant_reg == M1) ? m1_adr_i : m0_adr_i) : '0;
  assign slave_dat_o = busy ? ((grant_reg == M1) ? m1_dat_i : m0_dat_i) : '0;
  assign slave_sel_o = busy ? ((grant_reg == M1) ? m1_sel_i : m0_sel_i) : '0;

  assign m0_ack_o = busy && (grant_reg == M0) && sel_ack;
  assign m1_ack_o = busy && (grant_reg == M1) && sel_ack;
  assign m0_err_o = (state_reg == ERR) && (grant_reg == M0);
  assign m1_err_o = (state_reg == ERR) && (grant_reg == M1);
  assign m0_dat_o = (busy && (grant_reg == M0)) ? sel_rdata : '0;
  assign m1_dat_o = (busy && (grant_reg == M1)) ? sel_rdata : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      grant_reg      <= M0;
      last_grant_reg <= M1;
      slave_idx_reg  <= '0;
      count_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_stb_i || m1_stb_i) begin
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            slave_idx_reg  <= dec_idx;
            count_reg      <= '0;
            state_reg      <= dec_hit ? BUSY : ERR;
          end
        end
        BUSY: begin
          // Ack has priority over both abort and timeout in the same cycle.
          if (sel_ack)                    state_reg <= IDLE;
          else if (!granted_stb)          state_reg <= IDLE;
          else if (count_reg == CNT_LAST) state_reg <= ERR;
          if (count_reg != CNT_MAX) count_reg <= count_reg + 1'b1;
        end
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_switch_n.sv
// Scoreboard bench for wb_bus_switch_n (7 slaves, TIMEOUT_CYCLES = 4).
// Directed requests are queued per master; each queued request that must
// end in ack or err also pushes its hand-computed outcome onto a scoreboard.
// A monitor pops and compares whenever any master sees ack or err.
module tb_wb_bus_switch_n;

  localparam int NS = 7;
  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          abort_after;
  } req_t;

  typedef struct {
    logic        m;
    logic        is_err;
    logic [31:0] rdata;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [6:0]  stb_vec;
    int          stb_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              m0_stb_i = 0, m0_we_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [31:0]       m0_adr_i = 0, m0_dat_i = 0, m1_adr_i = 0, m1_dat_i = 0;
  logic [3:0]        m0_sel_i = 0, m1_sel_i = 0;
  logic [31:0]       m0_dat_o, m1_dat_o;
  logic              m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [NS-1:0]     slave_cyc_o, slave_stb_o;
  logic              slave_we_o;
  logic [31:0]       slave_adr_o, slave_dat_o;
  logic [3:0]        slave_sel_o;
  logic [NS*32-1:0]  slave_dat_i;
  logic [NS-1:0]     slave_ack_i = '0;

  wb_bus_switch_n #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i), .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i), .m0_dat_o (m0_dat_o),
    .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i), .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i), .m1_dat_o (m1_dat_o),
    .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .slave_cyc_o (slave_cyc_o), .slave_stb_o (slave_stb_o),
    .slave_we_o (slave_we_o), .slave_adr_o (slave_adr_o),
    .slave_dat_o (slave_dat_o), .slave_sel_o (slave_sel_o),
    .slave_dat_i (slave_dat_i), .slave_ack_i (slave_ack_i)
  );

  int checks = 0;
  int errors = 0;
  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  bit act[2];

  // Slave models: delay[k] = strobe cycle on which slave k acks (0 = never).
  int          delay [NS] = '{1, 1, 3, 1, 1, 0, 4};
  logic [31:0] sdat  [NS] = '{32'hA000_0000, 32'hA000_0001, 32'hDEAD_BEEF,
                              32'hA000_0003, 32'hA000_0004, 32'hA000_0005,
                              32'hA000_0006};
  int          scnt  [NS] = '{default: 0};

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_sdat
      assign slave_dat_i[gi*32 +: 32] = sdat[gi];
    end
  endgenerate

  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (slave_stb_o[k]) begin
        scnt[k] = scnt[k] + 1;
        slave_ack_i[k] = (delay[k] != 0) && (scnt[k] == delay[k]);
      end else begin
        scnt[k] = 0;
        slave_ack_i[k] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act_v, req_v);
    end
  endtask

  task automatic drive(input bit m, input req_t r, input logic s);
    if (m) begin
      m1_stb_i = s; m1_we_i = r.we; m1_adr_i = r.adr; m1_dat_i = r.dat; m1_sel_i = 4'hF;
    end else begin
      m0_stb_i = s; m0_we_i = r.we; m0_adr_i = r.adr; m0_dat_i = r.dat; m0_sel_i = 4'hF;
    end
  endtask

  // Master driver: holds a request until ack/err (or abort), then presents the next.
  task automatic master_loop(input bit m);
    req_t cur;
    req_t idle_req;
    bit   active;
    bit   done;
    int   cyc;
    idle_req = '{we: 1'b0, adr: 32'h0, dat: 32'h0, abort_after: 0};
    cur = idle_req;
    active = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk); #1;
      done = active && (m ? (m1_ack_o || m1_err_o) : (m0_ack_o || m0_err_o));
      @(posedge clk); #2;
      if (!rst) begin
        active = 1'b0;
        drive(m, idle_req, 1'b0);
      end else begin
        if (done) begin
          active = 1'b0;
          drive(m, idle_req, 1'b0);
        end else if (active) begin
          cyc++;
          if (cur.abort_after != 0 && cyc >= cur.abort_after) begin
            active = 1'b0;
            drive(m, idle_req, 1'b0);
          end else if (cyc > 40) begin
            checks++;
            errors++;
            $display("FAIL master%0d_wait actual=no_response required=ack_or_err", m);
            active = 1'b0;
            drive(m, idle_req, 1'b0);
          end
        end
        if (!active && (m ? q1.size() : q0.size()) > 0) begin
          cur = m ? q1.pop_front() : q0.pop_front();
          drive(m, cur, 1'b1);
          active = 1'b1;
          cyc = 0;
        end
      end
      act[m] = active;
    end
  endtask

  initial begin
    fork
      master_loop(1'b0);
      master_loop(1'b1);
    join_none
  end

  // Monitor: counts slave strobe cycles since the last outcome and checks each outcome.
  initial begin
    int         cnt;
    logic [6:0] vec;
    exp_t       e;
    cnt = 0;
    vec = '0;
    forever begin
      @(negedge clk); #1;
      if (slave_stb_o != '0) begin
        cnt++;
        vec = slave_stb_o;
      end
      if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
        chk("ack_err_exclusive", {62'd0, m0_ack_o & m0_err_o, m1_ack_o & m1_err_o}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual=m0:%b%b m1:%b%b required=none",
                   m0_ack_o, m0_err_o, m1_ack_o, m1_err_o);
        end else begin
          e = sb.pop_front();
          chk("event_master", {63'd0, m1_ack_o | m1_err_o}, {63'd0, e.m});
          chk("event_is_err", {63'd0, e.m ? m1_err_o : m0_err_o}, {63'd0, e.is_err});
          chk("stb_vector", {57'd0, vec}, {57'd0, e.stb_vec});
          chk("stb_cycles", 64'(cnt), 64'(e.stb_cnt));
          if (!e.is_err) begin
            chk("read_data", {32'd0, e.m ? m1_dat_o : m0_dat_o}, {32'd0, e.rdata});
            chk("slave_adr", {32'd0, slave_adr_o}, {32'd0, e.adr});
            chk("slave_we", {63'd0, slave_we_o}, {63'd0, e.we});
            if (e.we) chk("slave_wdat", {32'd0, slave_dat_o}, {32'd0, e.wdat});
          end
          if (e.m) chk("m0_quiet", {30'd0, m0_ack_o, m0_err_o, m0_dat_o}, 64'd0);
          else     chk("m1_quiet", {30'd0, m1_ack_o, m1_err_o, m1_dat_o}, 64'd0);
        end
        cnt = 0;
        vec = '0;
      end else if (slave_stb_o == '0) begin
        cnt = 0;
        vec = '0;
      end
    end
  end

  task automatic push_req(input bit m, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input int abort_after);
    req_t r;
    r = '{we: we, adr: adr, dat: dat, abort_after: abort_after};
    if (m) q1.push_back(r);
    else   q0.push_back(r);
  endtask

  task automatic push_exp(input bit m, input bit is_err, input logic [31:0] rdata,
                          input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                          input logic [6:0] vec, input int cnt);
    exp_t e;
    e = '{m: m, is_err: is_err, rdata: rdata, adr: adr, we: we, wdat: wdat,
          stb_vec: vec, stb_cnt: cnt};
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !act[0] && !act[1] && sb.size() == 0)
               && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=pending:%0d required=0", sb.size());
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ack_err"}, {60'd0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 64'd0);
    chk({tag, "_cyc_stb"}, {50'd0, slave_cyc_o, slave_stb_o}, 64'd0);
    chk({tag, "_m_dat"}, {m0_dat_o, m1_dat_o}, 64'd0);
    chk({tag, "_s_adr_dat"}, {slave_adr_o, slave_dat_o}, 64'd0);
    chk({tag, "_s_we_sel"}, {59'd0, slave_we_o, slave_sel_o}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;

    // m1 read of slave 2, ack on third strobe cycle.
    push_req(1'b1, 1'b0, 32'h1000_0204, 32'h0, 0);
    push_exp(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1000_0204, 1'b0, 32'h0, 7'b0000100, 3);
    wait_idle();

    // Both masters busy back to back: grants alternate starting with m0.
    push_req(1'b0, 1'b0, 32'h1000_0000, 32'h0, 0);
    push_req(1'b0, 1'b1, 32'h1000_0104, 32'h1234_5678, 0);
    push_req(1'b1, 1'b0, 32'h1000_0310, 32'h0, 0);
    push_req(1'b1, 1'b0, 32'h1000_0408, 32'h0, 0);
    push_exp(1'b0, 1'b0, 32'hA000_0000, 32'h1000_0000, 1'b0, 32'h0, 7'b0000001, 1);
    push_exp(1'b1, 1'b0, 32'hA000_0003, 32'h1000_0310, 1'b0, 32'h0, 7'b0001000, 1);
    push_exp(1'b0, 1'b0, 32'hA000_0001, 32'h1000_0104, 1'b1, 32'h1234_5678, 7'b0000010, 1);
    push_exp(1'b1, 1'b0, 32'hA000_0004, 32'h1000_0408, 1'b0, 32'h0, 7'b0010000, 1);
    wait_idle();

    // Unmapped address: one-cycle err, no slave strobe.
    push_req(1'b0, 1'b0, 32'h2000_0000, 32'h0, 0);
    push_exp(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0000000, 0);
    wait_idle();

    // Slave 5 never acks: four strobe cycles then err.
    push_req(1'b1, 1'b0, 32'h1000_0500, 32'h0, 0);
    push_exp(1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 7'b0100000, 4);
    wait_idle();

    // Slave 6 acks in the timeout cycle: ack wins.
    push_req(1'b0, 1'b0, 32'h1000_0600, 32'h0, 0);
    push_exp(1'b0, 1'b0, 32'hA000_0006, 32'h1000_0600, 1'b0, 32'h0, 7'b1000000, 4);
    wait_idle();

    // m1 aborts; that still counts as its turn, so the next tie goes to m0.
    push_req(1'b1, 1'b0, 32'h1000_0510, 32'h0, 2);
    wait_idle();
    push_req(1'b0, 1'b0, 32'h1000_0000, 32'h0, 0);
    push_req(1'b1, 1'b0, 32'h1000_0100, 32'h0, 0);
    push_exp(1'b0, 1'b0, 32'hA000_0000, 32'h1000_0000, 1'b0, 32'h0, 7'b0000001, 1);
    push_exp(1'b1, 1'b0, 32'hA000_0001, 32'h1000_0100, 1'b0, 32'h0, 7'b0000010, 1);
    wait_idle();

    // Reset while m0 is in BUSY; afterwards m0 wins the first tie again.
    push_req(1'b0, 1'b0, 32'h1000_0500, 32'h0, 0);
    begin
      int n;
      n = 0;
      while (slave_stb_o[5] !== 1'b1 && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk("busy_before_reset", {63'd0, slave_stb_o[5]}, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_quiet("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    push_req(1'b0, 1'b0, 32'h1000_0200, 32'h0, 0);
    push_req(1'b1, 1'b0, 32'h1000_0300, 32'h0, 0);
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1000_0200, 1'b0, 32'h0, 7'b0000100, 3);
    push_exp(1'b1, 1'b0, 32'hA000_0003, 32'h1000_0300, 1'b0, 32'h0, 7'b0001000, 1);
    wait_idle();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
